// File: rtl/clock_display_if.sv
// Time fields in, segment digits out for the display block.
// Master drives the clock side, slave is the display.
interface clock_display_if;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       set;
    logic       page_key;
    logic [6:0] hex3;
    logic [6:0] hex2;
    logic [6:0] hex1;
    logic [6:0] hex0;
    logic       page;
    logic       upd;

    modport master (
        output hour, min, sec, set, page_key,
        input  hex3, hex2, hex1, hex0, page, upd
    );

    modport slave (
        input  hour, min, sec, set, page_key,
        output hex3, hex2, hex1, hex0, page, upd
    );
endinterface

// File: rtl/clock_display.sv
// Seven-segment time display: sync, snapshot, BCD convert,
// tear-free digit load, page key debounce and set-mode blink.
module clock_display #(
    parameter int UPDATE_DIV   = 50000,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int BLINK_DIV    = 12500000
) (
    input logic             clk,
    input logic             rst_n,
    clock_display_if.slave  bus
);
    localparam int TW = $clog2(UPDATE_DIV + 1);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] DASH  = 7'b0111111;

    typedef enum logic [1:0] {IDLE, LOAD, CONV, WRITE} state_t;

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] r;
        r = BLANK;
        case (d)
            4'd0: r = 7'b1000000;
            4'd1: r = 7'b1111001;
            4'd2: r = 7'b0100100;
            4'd3: r = 7'b0110000;
            4'd4: r = 7'b0011001;
            4'd5: r = 7'b0010010;
            4'd6: r = 7'b0000010;
            4'd7: r = 7'b1111000;
            4'd8: r = 7'b0000000;
            4'd9: r = 7'b0010000;
            default: r = BLANK;
        endcase
        return r;
    endfunction

    logic [4:0] h_m, h_s, h_p;
    logic [5:0] m_m, m_s, m_p;
    logic [5:0] s_m, s_s, s_p;
    logic       set_m, set_s;
    logic       key_m, key_s;
    logic       stable;

    // two-flop synchronizers plus one extra stage for the stability compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_m <= '0; h_s <= '0; h_p <= '0;
            m_m <= '0; m_s <= '0; m_p <= '0;
            s_m <= '0; s_s <= '0; s_p <= '0;
            set_m <= 1'b0; set_s <= 1'b0;
            key_m <= 1'b1; key_s <= 1'b1;
        end else begin
            h_m <= bus.hour; h_s <= h_m; h_p <= h_s;
            m_m <= bus.min;  m_s <= m_m; m_p <= m_s;
            s_m <= bus.sec;  s_s <= s_m; s_p <= s_s;
            set_m <= bus.set;      set_s <= set_m;
            key_m <= bus.page_key; key_s <= key_m;
        end
    end

    assign stable = (h_s == h_p) && (m_s == m_p) && (s_s == s_p);

    logic [TW-1:0] tcnt;
    logic          tick;

    assign tick = (tcnt == TW'(UPDATE_DIV - 1));

    // free-running refresh divider, tick on wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcnt <= '0;
        else        tcnt <= tick ? '0 : tcnt + 1'b1;
    end

    logic [DW-1:0] dcnt;
    logic          key_st;
    logic          page_req;

    // accept a new key level after enough consecutive samples; press toggles page
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt     <= '0;
            key_st   <= 1'b1;
            page_req <= 1'b0;
        end else if (key_s == key_st) begin
            dcnt <= '0;
        end else if (dcnt == DW'(DEBOUNCE_CYC - 1)) begin
            dcnt   <= '0;
            key_st <= key_s;
            if (!key_s) page_req <= ~page_req;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    logic [BW-1:0] bcnt;
    logic          phase;
    logic          blank;

    // blink phase runs only in set mode; otherwise held on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (!set_s) begin
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (bcnt == BW'(BLINK_DIV - 1)) begin
            bcnt  <= '0;
            phase <= ~phase;
        end else begin
            bcnt <= bcnt + 1'b1;
        end
    end

    assign blank = set_s & ~phase;

    state_t     state, state_n;
    logic       pend;
    logic       go;
    logic [4:0] sh;
    logic [5:0] sm, ss;
    logic       page_q;
    logic [5:0] val, val_n, fb;
    logic [3:0] cnt, cnt_n;
    logic       ge10, fin, sel;
    logic       bad_a, bad_b;
    logic [3:0] tens_a, ones_a, tens_b, ones_b;
    logic [6:0] c3, c2, c1, c0;
    logic [6:0] d3, d2, d1, d0;

    assign go    = (tick | pend) & stable;
    assign ge10  = (val >= 6'd10);
    assign val_n = ge10 ? val - 6'd10 : val;
    assign cnt_n = cnt + {3'b000, ge10};
    assign fin   = (val_n < 6'd10);

    assign c3 = bad_a ? DASH : seg(tens_a);
    assign c2 = bad_a ? DASH : seg(ones_a);
    assign c1 = bad_b ? DASH : seg(tens_b);
    assign c0 = bad_b ? DASH : seg(ones_b);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // next-state: snapshot, convert both fields, write
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (go) state_n = LOAD;
            LOAD:    state_n = CONV;
            CONV:    if (fin && sel) state_n = WRITE;
            WRITE:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // a tick seen while idle but unstable is retried; busy ticks are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend <= 1'b0;
        else        pend <= (state == IDLE) && (tick | pend) && !stable;
    end

    // snapshot, field select and subtract-ten conversion datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh <= '0; sm <= '0; ss <= '0;
            page_q <= 1'b0;
            val <= '0; fb <= '0; cnt <= '0; sel <= 1'b0;
            bad_a <= 1'b0; bad_b <= 1'b0;
            tens_a <= '0; ones_a <= '0;
            tens_b <= '0; ones_b <= '0;
            d3 <= BLANK; d2 <= BLANK; d1 <= BLANK; d0 <= BLANK;
        end else begin
            unique case (state)
                IDLE: if (go) begin
                    sh     <= h_s;
                    sm     <= m_s;
                    ss     <= s_s;
                    page_q <= page_req;
                end
                LOAD: begin
                    val   <= page_q ? sm : {1'b0, sh};
                    fb    <= page_q ? ss : sm;
                    bad_a <= page_q ? (sm > 6'd59) : (sh > 5'd23);
                    bad_b <= page_q ? (ss > 6'd59) : (sm > 6'd59);
                    cnt   <= '0;
                    sel   <= 1'b0;
                end
                CONV: if (fin) begin
                    if (!sel) begin
                        tens_a <= cnt_n;
                        ones_a <= val_n[3:0];
                        val    <= fb;
                        cnt    <= '0;
                        sel    <= 1'b1;
                    end else begin
                        tens_b <= cnt_n;
                        ones_b <= val_n[3:0];
                    end
                end else begin
                    val <= val_n;
                    cnt <= cnt_n;
                end
                WRITE: begin
                    d3 <= c3; d2 <= c2; d1 <= c1; d0 <= c0;
                end
                default: ;
            endcase
        end
    end

    logic [6:0] hex3_q, hex2_q, hex1_q, hex0_q;
    logic       upd_q;
    logic       wr;

    assign wr = (state == WRITE);

    // registered outputs; new digits appear together with upd
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex3_q <= BLANK; hex2_q <= BLANK;
            hex1_q <= BLANK; hex0_q <= BLANK;
            upd_q  <= 1'b0;
        end else begin
            upd_q  <= wr;
            hex3_q <= blank ? BLANK : (wr ? c3 : d3);
            hex2_q <= blank ? BLANK : (wr ? c2 : d2);
            hex1_q <= blank ? BLANK : (wr ? c1 : d1);
            hex0_q <= blank ? BLANK : (wr ? c0 : d0);
        end
    end

    assign bus.hex3 = hex3_q;
    assign bus.hex2 = hex2_q;
    assign bus.hex1 = hex1_q;
    assign bus.hex0 = hex0_q;
    assign bus.page = page_q;
    assign bus.upd  = upd_q;
endmodule

// File: tb/tb_clock_display.sv
// Bench for clock_display: table vectors via a scoreboard
// queue, plus key, blink, unstable-field and reset sequences.
module tb_clock_display;
    localparam int UD = 40;
    localparam int DB = 20;
    localparam int BD = 8;
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] DASH  = 7'b0111111;

    typedef struct {
        logic       pg;
        logic [6:0] e3, e2, e1, e0;
    } exp_t;

    typedef struct {
        int   h, m, s;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    exp_t sbq[$];

    clock_display_if bus();

    clock_display #(
        .UPDATE_DIV(UD),
        .DEBOUNCE_CYC(DB),
        .BLINK_DIV(BD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return BLANK;
        endcase
    endfunction

    function automatic logic [13:0] pair(input int v, input int mx);
        if (v > mx) return {DASH, DASH};
        return {seg(v / 10), seg(v % 10)};
    endfunction

    function automatic exp_t model(input int h, input int m,
                                   input int s, input bit pg);
        exp_t e;
        logic [13:0] a, b;
        a = pg ? pair(m, 59) : pair(h, 23);
        b = pg ? pair(s, 59) : pair(m, 59);
        e.pg = pg;
        e.e3 = a[13:7]; e.e2 = a[6:0];
        e.e1 = b[13:7]; e.e0 = b[6:0];
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want)
            $display("FAIL %s: got %h want %h", nm, act, want);
        else
            passed++;
    endtask

    task automatic drive(input int h, input int m, input int s);
        bus.hour = 5'(h);
        bus.min  = 6'(m);
        bus.sec  = 6'(s);
    endtask

    task automatic wait_upd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.upd) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            $display("FAIL upd_timeout: got no upd want upd in 200 cycles");
        end
    endtask

    task automatic expect_next(input string nm);
        bit   ok;
        exp_t e;
        wait_upd(ok);
        if (sbq.size() == 0) begin
            total++;
            $display("FAIL %s: got empty scoreboard want entry", nm);
            return;
        end
        e = sbq.pop_front();
        if (ok) begin
            chk({nm, "_page"}, 32'(bus.page), 32'(e.pg));
            chk({nm, "_hex3"}, 32'(bus.hex3), 32'(e.e3));
            chk({nm, "_hex2"}, 32'(bus.hex2), 32'(e.e2));
            chk({nm, "_hex1"}, 32'(bus.hex1), 32'(e.e1));
            chk({nm, "_hex0"}, 32'(bus.hex0), 32'(e.e0));
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_hex"},
            {4'h0, bus.hex3, bus.hex2, bus.hex1, bus.hex0},
            {4'h0, BLANK, BLANK, BLANK, BLANK});
        chk({nm, "_page"}, 32'(bus.page), 32'd0);
        chk({nm, "_upd"}, 32'(bus.upd), 32'd0);
    endtask

    task automatic key_level(input logic lv, input int n);
        bus.page_key = lv;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vec_t tbl[8];
        bit   ok;
        exp_t eb;
        int   nupd, bad, nt, badrun;
        int   tr[$];
        bit   bl[60];

        tbl[0].h = 13; tbl[0].m = 45; tbl[0].s = 7;
        tbl[1].h = 0;  tbl[1].m = 0;  tbl[1].s = 0;
        tbl[2].h = 23; tbl[2].m = 59; tbl[2].s = 59;
        tbl[3].h = 9;  tbl[3].m = 5;  tbl[3].s = 30;
        tbl[4].h = 24; tbl[4].m = 10; tbl[4].s = 0;
        tbl[5].h = 12; tbl[5].m = 60; tbl[5].s = 0;
        tbl[6].h = 31; tbl[6].m = 63; tbl[6].s = 63;
        tbl[7].h = 1;  tbl[7].m = 2;  tbl[7].s = 3;
        foreach (tbl[i])
            tbl[i].e = model(tbl[i].h, tbl[i].m, tbl[i].s, 1'b0);

        drive(7, 33, 12);
        bus.set = 1'b1;
        bus.page_key = 1'b0;
        @(negedge clk);
        chk_reset("reset_a");
        repeat (4) @(negedge clk);
        chk_reset("reset_b");
        bus.set = 1'b0;
        bus.page_key = 1'b1;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            wait_upd(ok);
            drive(tbl[i].h, tbl[i].m, tbl[i].s);
            sbq.push_back(tbl[i].e);
            expect_next($sformatf("vec%0d", i));
        end

        wait_upd(ok);
        nupd = 0;
        for (int i = 0; i < 3 * UD; i++) begin
            drive(13, 45, i % 60);
            @(negedge clk);
            if (bus.upd) nupd++;
        end
        chk("unstable_no_upd", 32'(nupd), 32'd0);
        drive(13, 45, 7);

        wait_upd(ok);
        key_level(1'b0, DB + 5);
        key_level(1'b1, DB + 5);
        sbq.push_back(model(13, 45, 7, 1'b1));
        expect_next("page1");

        wait_upd(ok);
        key_level(1'b0, DB - 1);
        key_level(1'b1, 2);
        wait_upd(ok);
        sbq.push_back(model(13, 45, 7, 1'b1));
        expect_next("glitch");

        wait_upd(ok);
        drive(13, 45, 60);
        sbq.push_back(model(13, 45, 60, 1'b1));
        expect_next("page1_range");

        eb = model(13, 45, 60, 1'b1);
        bus.set = 1'b1;
        bad = 0;
        foreach (bl[i]) begin
            @(negedge clk);
            bl[i] = (bus.hex3 == BLANK);
            if (bl[i]) begin
                if ({bus.hex2, bus.hex1, bus.hex0} !== {BLANK, BLANK, BLANK})
                    bad++;
            end else if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0} !==
                         {eb.e3, eb.e2, eb.e1, eb.e0}) begin
                bad++;
            end
        end
        for (int i = 1; i < 60; i++)
            if (bl[i] != bl[i-1]) tr.push_back(i);
        nt = tr.size();
        badrun = 0;
        for (int k = 1; k < nt; k++)
            if (tr[k] - tr[k-1] != BD) badrun++;
        chk("blink_values", 32'(bad), 32'd0);
        chk("blink_toggles", 32'(nt >= 5), 32'd1);
        chk("blink_period", 32'(badrun), 32'd0);

        bus.set = 1'b0;
        repeat (3) @(negedge clk);
        chk("unblink_3cyc",
            {4'h0, bus.hex3, bus.hex2, bus.hex1, bus.hex0},
            {4'h0, eb.e3, eb.e2, eb.e1, eb.e0});
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if ({bus.hex3, bus.hex2, bus.hex1, bus.hex0} !==
                {eb.e3, eb.e2, eb.e1, eb.e0}) bad++;
        end
        chk("unblink_steady", 32'(bad), 32'd0);

        wait_upd(ok);
        repeat (UD - 13) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset("reset_conv");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sbq.push_back(model(13, 45, 60, 1'b0));
        expect_next("after_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
